// File: rtl/rom_fetch_arb.sv
`default_nettype none
// ============================================================================
// rom_fetch_arb : three-client ROM fetch arbiter onto a 16-bit SDRAM read port.
// Option ROM_FETCH_CACHE_EN adds a one-entry cache per client.
// Revision: 1.0
// ============================================================================
module rom_fetch_arb #(
  parameter logic [22:0] TILES_BASE   = 23'h000000,
  parameter logic [22:0] SPRITES_BASE = 23'h080000,
  parameter logic [22:0] THEME_BASE   = 23'h200000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        load_en,
  input  logic        tiles_req,
  input  logic [17:0] tiles_addr,
  output logic        tiles_ack,
  output logic [31:0] tiles_data,
  input  logic        sprites_req,
  input  logic [18:0] sprites_addr,
  output logic        sprites_ack,
  output logic [31:0] sprites_data,
  input  logic        theme_req,
  input  logic [18:0] theme_addr,
  output logic        theme_ack,
  output logic [7:0]  theme_data,
  output logic        sdr_rd,
  output logic [22:0] sdr_addr,
  input  logic        sdr_rdy,
  input  logic [15:0] sdr_dout,
  output logic        busy
);

  typedef enum logic [2:0] {
    C_ST_IDLE = 3'd0,
    C_ST_RD0  = 3'd1,
    C_ST_W0   = 3'd2,
    C_ST_RD1  = 3'd3,
    C_ST_W1   = 3'd4,
    C_ST_DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    C_CL_TILES   = 2'd0,
    C_CL_SPRITES = 2'd1,
    C_CL_THEME   = 2'd2
  } client_t;

  state_t      r_state;
  client_t     r_client;
  logic        r_byte_sel;
  logic [15:0] r_w0;
  logic [15:0] r_w1;

  logic        w_tiles_hit;
  logic        w_sprites_hit;
  logic        w_theme_hit;
  logic [31:0] w_tiles_cdata;
  logic [31:0] w_sprites_cdata;
  logic [31:0] w_theme_cdata;

  logic        w_gnt;
  client_t     w_gnt_client;
  logic [22:0] w_gnt_word0;
  logic        w_gnt_hit;
  logic [31:0] w_gnt_cdata;

  assign busy = (r_state != C_ST_IDLE);

  // A client whose ack is high right now was just served; masking it stops a
  // request still held during the ack cycle from being fetched a second time.
  always_comb begin
    w_gnt        = 1'b1;
    w_gnt_client = C_CL_TILES;
    w_gnt_word0  = '0;
    w_gnt_hit    = 1'b0;
    w_gnt_cdata  = '0;
    if (sprites_req && !sprites_ack) begin
      w_gnt_client = C_CL_SPRITES;
      w_gnt_word0  = SPRITES_BASE + {3'b000, sprites_addr, 1'b0};
      w_gnt_hit    = w_sprites_hit;
      w_gnt_cdata  = w_sprites_cdata;
    end else if (tiles_req && !tiles_ack) begin
      w_gnt_client = C_CL_TILES;
      w_gnt_word0  = TILES_BASE + {4'b0000, tiles_addr, 1'b0};
      w_gnt_hit    = w_tiles_hit;
      w_gnt_cdata  = w_tiles_cdata;
    end else if (theme_req && !theme_ack) begin
      w_gnt_client = C_CL_THEME;
      w_gnt_word0  = THEME_BASE + {5'b00000, theme_addr[18:1]};
      w_gnt_hit    = w_theme_hit;
      w_gnt_cdata  = w_theme_cdata;
    end else begin
      w_gnt = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= C_ST_IDLE;
      r_client     <= C_CL_TILES;
      r_byte_sel   <= 1'b0;
      r_w0         <= '0;
      r_w1         <= '0;
      sdr_rd       <= 1'b0;
      sdr_addr     <= '0;
      tiles_ack    <= 1'b0;
      tiles_data   <= '0;
      sprites_ack  <= 1'b0;
      sprites_data <= '0;
      theme_ack    <= 1'b0;
      theme_data   <= '0;
    end else begin
      sdr_rd      <= 1'b0;
      tiles_ack   <= 1'b0;
      sprites_ack <= 1'b0;
      theme_ack   <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (w_gnt && !load_en) begin
            r_client   <= w_gnt_client;
            r_byte_sel <= theme_addr[0];
            if (w_gnt_hit) begin
              r_w0    <= w_gnt_cdata[15:0];
              r_w1    <= w_gnt_cdata[31:16];
              r_state <= C_ST_DONE;
            end else begin
              sdr_rd   <= 1'b1;
              sdr_addr <= w_gnt_word0;
              r_state  <= C_ST_RD0;
            end
          end
        end
        C_ST_RD0: r_state <= C_ST_W0;
        C_ST_W0: begin
          if (sdr_rdy) begin
            r_w0 <= sdr_dout;
            if (r_client == C_CL_THEME) begin
              r_state <= C_ST_DONE;
            end else begin
              sdr_rd   <= 1'b1;
              sdr_addr <= sdr_addr + 23'd1;
              r_state  <= C_ST_RD1;
            end
          end
        end
        C_ST_RD1: r_state <= C_ST_W1;
        C_ST_W1: begin
          if (sdr_rdy) begin
            r_w1    <= sdr_dout;
            r_state <= C_ST_DONE;
          end
        end
        C_ST_DONE: begin
          r_state <= C_ST_IDLE;
          case (r_client)
            C_CL_TILES: begin
              tiles_ack  <= 1'b1;
              tiles_data <= {r_w1, r_w0};
            end
            C_CL_SPRITES: begin
              sprites_ack  <= 1'b1;
              sprites_data <= {r_w1, r_w0};
            end
            default: begin
              theme_ack  <= 1'b1;
              theme_data <= r_byte_sel ? r_w0[15:8] : r_w0[7:0];
            end
          endcase
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

`ifdef ROM_FETCH_CACHE_EN
  logic [18:0] r_addr;
  logic        r_tc_valid;
  logic        r_sc_valid;
  logic        r_thc_valid;
  logic [17:0] r_tc_addr;
  logic [18:0] r_sc_addr;
  logic [18:0] r_thc_addr;
  logic [31:0] r_tc_data;
  logic [31:0] r_sc_data;
  logic [15:0] r_thc_data;

  assign w_tiles_hit     = r_tc_valid  && (r_tc_addr  == tiles_addr);
  assign w_sprites_hit   = r_sc_valid  && (r_sc_addr  == sprites_addr);
  assign w_theme_hit     = r_thc_valid && (r_thc_addr == theme_addr);
  assign w_tiles_cdata   = r_tc_data;
  assign w_sprites_cdata = r_sc_data;
  assign w_theme_cdata   = {16'h0000, r_thc_data};

  // Theme entries keep the whole SDRAM word so a hit can reuse the byte select.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_tc_valid  <= 1'b0;
      r_sc_valid  <= 1'b0;
      r_thc_valid <= 1'b0;
      r_tc_addr   <= '0;
      r_sc_addr   <= '0;
      r_thc_addr  <= '0;
      r_tc_data   <= '0;
      r_sc_data   <= '0;
      r_thc_data  <= '0;
    end else begin
      if ((r_state == C_ST_IDLE) && w_gnt && !load_en) begin
        case (w_gnt_client)
          C_CL_TILES:   r_addr <= {1'b0, tiles_addr};
          C_CL_SPRITES: r_addr <= sprites_addr;
          default:      r_addr <= theme_addr;
        endcase
      end
      if (load_en) begin
        r_tc_valid  <= 1'b0;
        r_sc_valid  <= 1'b0;
        r_thc_valid <= 1'b0;
      end else if (r_state == C_ST_DONE) begin
        case (r_client)
          C_CL_TILES: begin
            r_tc_valid <= 1'b1;
            r_tc_addr  <= r_addr[17:0];
            r_tc_data  <= {r_w1, r_w0};
          end
          C_CL_SPRITES: begin
            r_sc_valid <= 1'b1;
            r_sc_addr  <= r_addr;
            r_sc_data  <= {r_w1, r_w0};
          end
          default: begin
            r_thc_valid <= 1'b1;
            r_thc_addr  <= r_addr;
            r_thc_data  <= r_w0;
          end
        endcase
      end
    end
  end
`else
  assign w_tiles_hit     = 1'b0;
  assign w_sprites_hit   = 1'b0;
  assign w_theme_hit     = 1'b0;
  assign w_tiles_cdata   = '0;
  assign w_sprites_cdata = '0;
  assign w_theme_cdata   = '0;
`endif

endmodule
`default_nettype wire
